ifu_pcgen: RTL and testbench

//  Fetch PC generator. Owns the architectural fetch PC and offers it to the instruction fetcher

---
 rtl/ifu_pcgen_pkg.sv | 19 +
 rtl/ifu_pcgen_tgt.sv | 32 +++
 rtl/ifu_pcgen.sv | 125 ++++++++++++
 tb/tb_ifu_pcgen.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pcgen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ifu_pcgen_pkg
//  Description : Shared definitions for the fetch PC generator: state
//                encodings, default reset PC and sequential fetch increment.
//  Revision    : 1.0  initial release
// ============================================================================
package ifu_pcgen_pkg;

    // Fetch PC generator states
    localparam logic [1:0] C_ST_BOOT = 2'd0;   // first cycle after reset, no request
    localparam logic [1:0] C_ST_RUN  = 2'd1;   // fetching, accepting EXU results
    localparam logic [1:0] C_ST_HALT = 2'd2;   // misaligned target, waiting for trap PC

    localparam logic [31:0] C_RESET_PC = 32'h8000_0000;
    localparam logic [31:0] C_PC_INCR  = 32'd4;   // no compressed instructions

endpackage : ifu_pcgen_pkg
`default_nettype wire

// File: rtl/ifu_pcgen_tgt.sv
`default_nettype none
// ============================================================================
//  Module      : ifu_pcgen_tgt
//  Description : Redirect target former. Adds base and offset (mod 2^32),
//                clears bit0 for JALR and flags a target whose bit1 is set.
//  Ports       : i_pc      redirect base
//                i_pcadd   redirect offset (sign-extended immediate)
//                i_jalr    clear target bit0
//                o_target  formed target address
//                o_misalign target bit1 set (not on a 4-byte boundary)
//  Revision    : 1.0  initial release
// ============================================================================
module ifu_pcgen_tgt (
    input  logic [31:0] i_pc,
    input  logic [31:0] i_pcadd,
    input  logic        i_jalr,
    output logic [31:0] o_target,
    output logic        o_misalign
);

    logic [31:0] w_sum;

    always_comb begin
        w_sum    = i_pc + i_pcadd;
        o_target = {w_sum[31:1], w_sum[0] & ~i_jalr};
        // Only bit1 matters: bit0 is either cleared by JALR or cannot be set
        // for PC-relative targets with even offsets.
        o_misalign = o_target[1];
    end

endmodule : ifu_pcgen_tgt
`default_nettype wire

// File: rtl/ifu_pcgen.sv
`default_nettype none
// ============================================================================
//  Module      : ifu_pcgen
//  Description : Fetch PC generator. Holds the fetch PC, offers it to the
//                fetcher over val/rdy, advances it on every accepted fetch,
//                applies branch/jump redirects with a flush pulse and halts
//                on a misaligned target until the trap controller supplies
//                the handler PC.
//  Ports       : clk, rst            clock, synchronous active-high reset
//                hs_ex4pc_val/rdy    EXU result handshake (rdy low in HALT)
//                i_setpc/i_pc/i_pcadd/i_jalr  redirect request and operands
//                hs_pc4if_val/rdy    fetch request handshake
//                o_fetch_pc          current fetch address
//                o_flush             one-cycle discard of in-flight fetches
//                o_excp/o_excp_tval  misaligned-target pulse and address
//                i_trap_val/i_trap_pc handler PC from the trap controller
//  Revision    : 1.0  initial release
// ============================================================================
module ifu_pcgen
    import ifu_pcgen_pkg::*;
#(
    parameter logic [31:0] RESET_PC = C_RESET_PC,
    parameter logic [31:0] PC_INCR  = C_PC_INCR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hs_ex4pc_val,
    output logic        hs_pc4ex_rdy,
    input  logic        i_setpc,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_pcadd,
    input  logic        i_jalr,
    output logic        hs_pc4if_val,
    input  logic        hs_if4pc_rdy,
    output logic [31:0] o_fetch_pc,
    output logic        o_flush,
    output logic        o_excp,
    output logic [31:0] o_excp_tval,
    input  logic        i_trap_val,
    input  logic [31:0] i_trap_pc
);

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic        r_flush;
    logic        r_excp;
    logic [31:0] r_excp_tval;

    logic [31:0] w_target;
    logic        w_misalign;
    logic        w_run;
    logic        w_redir_acc;
    logic        w_fetch_hs;
    logic [31:0] w_trap_pc;

    ifu_pcgen_tgt u_tgt (
        .i_pc       (i_pc),
        .i_pcadd    (i_pcadd),
        .i_jalr     (i_jalr),
        .o_target   (w_target),
        .o_misalign (w_misalign)
    );

    always_comb begin
        w_run       = (r_state == C_ST_RUN);
        w_redir_acc = hs_ex4pc_val & w_run & i_setpc;
        w_fetch_hs  = w_run & hs_if4pc_rdy;
        w_trap_pc   = i_trap_pc & ~32'h3;
    end

    // Priority within a cycle: reset > trap > redirect > fetch increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= C_ST_BOOT;
            r_pc        <= RESET_PC;
            r_flush     <= 1'b0;
            r_excp      <= 1'b0;
            r_excp_tval <= 32'h0;
        end else begin
            r_flush <= 1'b0;
            r_excp  <= 1'b0;
            case (r_state)
                C_ST_BOOT: begin
                    r_state <= C_ST_RUN;
                end
                C_ST_RUN: begin
                    if (i_trap_val) begin
                        r_pc    <= w_trap_pc;
                        r_flush <= 1'b1;
                    end else if (w_redir_acc) begin
                        r_flush <= 1'b1;
                        if (w_misalign) begin
                            // PC is left alone; the handler PC replaces it later.
                            r_excp      <= 1'b1;
                            r_excp_tval <= w_target;
                            r_state     <= C_ST_HALT;
                        end else begin
                            r_pc <= w_target;
                        end
                    end else if (w_fetch_hs) begin
                        r_pc <= r_pc + PC_INCR;
                    end
                end
                C_ST_HALT: begin
                    if (i_trap_val) begin
                        r_pc    <= w_trap_pc;
                        r_state <= C_ST_RUN;
                    end
                end
                default: begin
                    r_state <= C_ST_BOOT;
                end
            endcase
        end
    end

    assign hs_pc4if_val = w_run;
    assign hs_pc4ex_rdy = w_run;
    assign o_fetch_pc   = r_pc;
    assign o_flush      = r_flush;
    assign o_excp       = r_excp;
    assign o_excp_tval  = r_excp_tval;

endmodule : ifu_pcgen
`default_nettype wire

// File: tb/tb_ifu_pcgen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ifu_pcgen
//  Description : Self-checking bench for ifu_pcgen. Directed scenarios then
//                randomized traffic, all compared against a behavioural
//                model of the fetch PC generator.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ifu_pcgen;

    logic        clk;
    logic        rst;
    logic        hs_ex4pc_val;
    logic        hs_pc4ex_rdy;
    logic        i_setpc;
    logic [31:0] i_pc;
    logic [31:0] i_pcadd;
    logic        i_jalr;
    logic        hs_pc4if_val;
    logic        hs_if4pc_rdy;
    logic [31:0] o_fetch_pc;
    logic        o_flush;
    logic        o_excp;
    logic [31:0] o_excp_tval;
    logic        i_trap_val;
    logic [31:0] i_trap_pc;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: mode 0 = booting, 1 = running, 2 = halted
    int          m_mode;
    logic [31:0] m_pc;
    logic        m_flush;
    logic        m_excp;
    logic [31:0] m_tval;

    ifu_pcgen dut (
        .clk          (clk),
        .rst          (rst),
        .hs_ex4pc_val (hs_ex4pc_val),
        .hs_pc4ex_rdy (hs_pc4ex_rdy),
        .i_setpc      (i_setpc),
        .i_pc         (i_pc),
        .i_pcadd      (i_pcadd),
        .i_jalr       (i_jalr),
        .hs_pc4if_val (hs_pc4if_val),
        .hs_if4pc_rdy (hs_if4pc_rdy),
        .o_fetch_pc   (o_fetch_pc),
        .o_flush      (o_flush),
        .o_excp       (o_excp),
        .o_excp_tval  (o_excp_tval),
        .i_trap_val   (i_trap_val),
        .i_trap_pc    (i_trap_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare every output against the model.
    task automatic check_all();
        chk("if_val",  {31'b0, hs_pc4if_val}, {31'b0, m_mode == 1});
        chk("ex_rdy",  {31'b0, hs_pc4ex_rdy}, {31'b0, m_mode == 1});
        chk("pc",      o_fetch_pc, m_pc);
        chk("flush",   {31'b0, o_flush}, {31'b0, m_flush});
        chk("excp",    {31'b0, o_excp},  {31'b0, m_excp});
        chk("tval",    o_excp_tval, m_tval);
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        logic [31:0] t;
        if (rst) begin
            m_mode = 0; m_pc = 32'h8000_0000;
            m_flush = 0; m_excp = 0; m_tval = 0;
            return;
        end
        m_flush = 0;
        m_excp  = 0;
        if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 2) begin
            if (i_trap_val) begin
                m_pc   = (i_trap_pc / 4) * 4;
                m_mode = 1;
            end
        end else begin
            if (i_trap_val) begin
                m_pc    = (i_trap_pc / 4) * 4;
                m_flush = 1;
            end else if (hs_ex4pc_val && i_setpc) begin
                t = i_pc + i_pcadd;
                if (i_jalr && t % 2 == 1) t = t - 1;
                m_flush = 1;
                if ((t / 2) % 2 == 1) begin
                    m_excp = 1;
                    m_tval = t;
                    m_mode = 2;
                end else begin
                    m_pc = t;
                end
            end else if (hs_if4pc_rdy) begin
                m_pc = m_pc + 4;
            end
        end
    endtask

    // One clock: update model, pass the edge, check at the falling edge.
    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle_inputs();
        hs_ex4pc_val = 0; i_setpc = 0; i_jalr = 0;
        i_pc = 0; i_pcadd = 0; i_trap_val = 0; i_trap_pc = 0;
    endtask

    task automatic redirect(input logic [31:0] pc, input logic [31:0] add, input logic jalr);
        hs_ex4pc_val = 1; i_setpc = 1; i_pc = pc; i_pcadd = add; i_jalr = jalr;
        cycle();
        idle_inputs();
    endtask

    initial begin
        rst = 1; hs_if4pc_rdy = 1;
        idle_inputs();
        m_mode = 0; m_pc = 32'h8000_0000; m_flush = 0; m_excp = 0; m_tval = 0;
        @(negedge clk);
        // 1: reset then sequential fetch
        repeat (3) cycle();
        chk("rst_pc",  o_fetch_pc, 32'h8000_0000);
        chk("rst_val", {31'b0, hs_pc4if_val}, 32'h0);
        rst = 0;
        cycle();                                       // BOOT -> RUN
        chk("t1_pc0", o_fetch_pc, 32'h8000_0000);
        chk("t1_val", {31'b0, hs_pc4if_val}, 32'h1);
        cycle();
        cycle();
        chk("t1_pc2", o_fetch_pc, 32'h8000_0008);
        // 2: fetcher stall holds the address
        hs_if4pc_rdy = 0;
        repeat (3) cycle();
        chk("t2_hold", o_fetch_pc, 32'h8000_0008);
        hs_if4pc_rdy = 1;
        cycle();
        chk("t2_next", o_fetch_pc, 32'h8000_000C);
        // 3: backward branch beats a same-cycle fetch
        redirect(32'h8000_0100, 32'hFFFF_FFF0, 1'b0);
        chk("t3_pc",    o_fetch_pc, 32'h8000_00F0);
        chk("t3_flush", {31'b0, o_flush}, 32'h1);
        cycle();
        chk("t3_seq",   o_fetch_pc, 32'h8000_00F4);
        chk("t3_nofl",  {31'b0, o_flush}, 32'h0);
        // 4: JALR bit0 clear, then misaligned -> HALT -> trap
        redirect(32'h0000_1001, 32'h0, 1'b1);
        chk("t4_pc", o_fetch_pc, 32'h0000_1000);
        chk("t4_noex", {31'b0, o_excp}, 32'h0);
        redirect(32'h0000_1002, 32'h0, 1'b1);
        chk("t4_excp", {31'b0, o_excp}, 32'h1);
        chk("t4_tval", o_excp_tval, 32'h0000_1002);
        chk("t4_halt", {31'b0, hs_pc4if_val}, 32'h0);
        hs_ex4pc_val = 1; i_setpc = 1; i_pc = 32'h40; // ignored while halted
        cycle();
        idle_inputs();
        i_trap_val = 1; i_trap_pc = 32'h0000_2000;
        cycle();
        idle_inputs();
        chk("t4_trap", o_fetch_pc, 32'h0000_2000);
        chk("t4_run",  {31'b0, hs_pc4if_val}, 32'h1);
        // 5: consumed non-redirect result, then 32-bit wrap
        hs_ex4pc_val = 1; i_setpc = 0; i_pc = 32'h1234_0000;
        cycle();
        idle_inputs();
        chk("t5_seq", o_fetch_pc, 32'h0000_2004);
        chk("t5_nofl", {31'b0, o_flush}, 32'h0);
        redirect(32'hFFFF_FFF0, 32'h0000_000C, 1'b0);
        chk("t5_top", o_fetch_pc, 32'hFFFF_FFFC);
        cycle();
        chk("t5_wrap", o_fetch_pc, 32'h0000_0000);
        // 6: reset wins over a same-cycle redirect
        rst = 1; hs_ex4pc_val = 1; i_setpc = 1; i_pc = 32'h0000_0302; i_pcadd = 0;
        cycle();
        idle_inputs();
        chk("t6_pc", o_fetch_pc, 32'h8000_0000);
        rst = 0;
        cycle();
        chk("t6_nofl", {31'b0, o_flush}, 32'h0);
        chk("t6_noex", {31'b0, o_excp}, 32'h0);
        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst          = ($urandom_range(0, 99) == 0);
            hs_if4pc_rdy = ($urandom_range(0, 3) != 0);
            hs_ex4pc_val = ($urandom_range(0, 2) == 0);
            i_setpc      = ($urandom_range(0, 1) == 0);
            i_jalr       = ($urandom_range(0, 3) == 0);
            i_pc         = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 : $urandom;
            i_pcadd      = $urandom;
            if ($urandom_range(0, 1) == 0) i_pcadd[1:0] = 2'b00;
            if ($urandom_range(0, 1) == 0) i_pc[1:0]    = 2'b00;
            i_trap_val   = ($urandom_range(0, 19) == 0);
            i_trap_pc    = $urandom;
            cycle();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_ifu_pcgen
`default_nettype wire
